rgb_pixel_packer: RTL and testbench
===================================

// Module: rgb_pixel_packer
// PURPOSE
//  Sits directly downstream of the UART byte receiver. Consumes the serial
//  R,G,B byte stream and packs each triple into one 24-bit pixel word.
//  Writes each pixel into the frame-buffer BRAM port with a linear address.
//  Holds the completed frame for the inference engine until it is acknowledged.
// PARAMETERS
//  IMG_W   224  pixels per row
//  IMG_H   224  rows per frame
//  ADDR_W  16   frame-buffer address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
//  COL_W   8    column counter width; must satisfy 2**COL_W >= IMG_W
//  ROW_W   8    row counter width; must satisfy 2**ROW_W >= IMG_H
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous reset, active-low
//  in_data     in   8       byte from the UART receiver
//  in_valid    in   1       one-cycle strobe, in_data is valid
//  frame_ack   in   1       inference engine releases the frame buffer; 1-cycle pulse
//  wr_en       out  1       frame-buffer write strobe
//  wr_addr     out  ADDR_W  pixel index = row*IMG_W + col
//  wr_data     out  24      {R,G,B}; R is the first byte of the triple
//  col         out  COL_W   column of the next pixel to be written
//  row         out  ROW_W   row of the next pixel to be written
//  busy        out  1       state == FILL
//  frame_done  out  1       sticky; full frame written
//  overflow    out  1       sticky; byte arrived while in DONE
//  checksum    out  16      running byte sum (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0): all outputs 0, chan_idx=0, pixel index=0, state=IDLE.
//  State machine: IDLE -> FILL on the first accepted byte.
//    FILL -> DONE on the cycle the last pixel (index IMG_W*IMG_H-1) is written.
//    DONE -> IDLE on frame_ack.
//  Packing: chan_idx cycles 0,1,2. Bytes are latched into R, G, B registers in that order.
//  Write: wr_en is high for exactly 1 cycle, on the cycle after the in_valid of the B byte.
//    wr_data and wr_addr are registered and valid only while wr_en=1.
//    Between writes, wr_data and wr_addr hold their last value.
//  Counters:
//    col increments on each write; at IMG_W-1 it wraps to 0 and row increments.
//    The pixel index increments by 1 on each write.
//    col and row update in the same cycle as wr_en.
//  Frame done: frame_done rises in the same cycle as the final wr_en.
//    On that cycle col and row wrap to 0.
//  Overflow:
//    In DONE, in_valid bytes are dropped: no latch, no wr_en.
//    overflow is set and stays set until frame_ack.
//  frame_ack:
//    In any state it clears frame_done, overflow, checksum, chan_idx, col, row and the
//    pixel index, and moves the block to IDLE.
//    In IDLE or FILL it aborts the partial frame (resync); a pending wr_en is cancelled.
//  Simultaneous events: if in_valid and frame_ack arrive in the same cycle, frame_ack wins.
//    The byte is discarded and overflow is not set.
//  Reset mid-frame: the partial pixel is discarded and no wr_en is issued.
//    The next byte is treated as R of pixel 0.
//  Throughput: one byte per cycle is sustained with no stalls. There is no backpressure.
// CONFIGURATION
//  Macro CHECKSUM_EN.
//  Defined:
//    checksum = 16-bit modulo-2^16 sum of every accepted byte (bytes dropped in DONE are
//    excluded).
//    It updates the cycle after each accepted byte.
//    It is frozen while in DONE and cleared by frame_ack or reset.
//  Undefined: the checksum logic is removed and the port is tied to 16'h0000.
// TESTING  (use IMG_W=4, IMG_H=2 unless noted)
//  Bytes 11,22,33 -> one wr_en pulse, cycle after the 33 strobe:
//    wr_addr=0, wr_data=24'h112233; then col=1, row=0.
//  24 bytes back-to-back -> 8 writes at addr 0..7.
//    col/row: after the 4th write col=0, row=1.
//    frame_done=1 on the 8th wr_en; busy=0 afterwards.
//  Frame full, then 1 extra byte -> overflow=1, no wr_en.
//    frame_ack -> overflow=0, frame_done=0, IDLE.
//  4 bytes, then frame_ack, then AA,BB,CC -> single write at addr 0 with data 24'hAABBCC.
//  rst low for 1 cycle after 2 bytes of a pixel -> all outputs 0.
//    The next 3 bytes write addr 0.
//  CHECKSUM_EN, 24 bytes of FF -> checksum=16'h17E8 at frame_done.
//    Without CHECKSUM_EN -> checksum=0.

Source files
------------

// File: rtl/rgb_pixel_packer.sv
// Packs the UART R,G,B byte stream into 24-bit pixels and writes them linearly into the frame buffer.
// Write issues 1 cycle after the B byte; no backpressure; optional checksum via CHECKSUM_EN.
module rgb_pixel_packer #(
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int ADDR_W = 16,
    parameter int COL_W  = 8,
    parameter int ROW_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              frame_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_H - 1);

    state_t            state, state_nxt;
    logic [1:0]        chan_idx;
    logic [7:0]        r_reg, g_reg;
    logic [ADDR_W-1:0] pix_idx;
    logic              accept, pix_write, last_pix;

    // frame_ack wins over a coincident byte, and bytes are dropped once the frame is full
    assign accept    = in_valid && !frame_ack && (state != DONE);
    assign pix_write = accept && (chan_idx == 2'd2);
    assign last_pix  = (pix_idx == LAST_PIX);
    assign busy      = (state == FILL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_ack) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = FILL;
                FILL:    if (pix_write && last_pix) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chan_idx   <= 2'd0;
            r_reg      <= 8'h00;
            g_reg      <= 8'h00;
            pix_idx    <= '0;
            col        <= '0;
            row        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 24'h0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (frame_ack) begin
                chan_idx   <= 2'd0;
                pix_idx    <= '0;
                col        <= '0;
                row        <= '0;
                frame_done <= 1'b0;
                overflow   <= 1'b0;
            end else begin
                if (in_valid && (state == DONE)) overflow <= 1'b1;
                if (accept) begin
                    case (chan_idx)
                        2'd0:    begin r_reg <= in_data; chan_idx <= 2'd1; end
                        2'd1:    begin g_reg <= in_data; chan_idx <= 2'd2; end
                        default: chan_idx <= 2'd0;
                    endcase
                end
                if (pix_write) begin
                    wr_en   <= 1'b1;
                    wr_addr <= pix_idx;
                    wr_data <= {r_reg, g_reg, in_data};
                    if (last_pix) begin
                        pix_idx    <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        pix_idx <= pix_idx + ADDR_W'(1);
                    end
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= (row == LAST_ROW) ? '0 : row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
            end
        end
    end

`ifdef CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           csum <= 16'h0000;
        else if (frame_ack) csum <= 16'h0000;
        else if (accept)    csum <= csum + {8'h00, in_data};
    end

    assign checksum = csum;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rgb_pixel_packer.sv
// Directed bench for rgb_pixel_packer on a 4x2 frame.
module tb_rgb_pixel_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        frame_ack;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic [1:0]  col;
    logic [0:0]  row;
    logic        busy;
    logic        frame_done;
    logic        overflow;
    logic [15:0] checksum;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_csum;

    rgb_pixel_packer #(
        .IMG_W(4), .IMG_H(2), .ADDR_W(3), .COL_W(2), .ROW_W(1)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .col(col), .row(row), .busy(busy), .frame_done(frame_done),
        .overflow(overflow), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drives one byte for one posedge; returns at the following negedge
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; frame_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // single pixel
        send(8'h11);
        check("p0_busy", 32'(busy), 32'd1);
        send(8'h22);
        check("p0_no_wr_early", 32'(wr_en), 32'd0);
        send(8'h33);
        check("p0_wr_en", 32'(wr_en), 32'd1);
        check("p0_wr_addr", 32'(wr_addr), 32'd0);
        check("p0_wr_data", 32'(wr_data), 32'h112233);
        check("p0_col", 32'(col), 32'd1);
        check("p0_row", 32'(row), 32'd0);
`ifdef CHECKSUM_EN
        check("p0_checksum", 32'(checksum), 32'h0066);
`else
        check("p0_checksum", 32'(checksum), 32'h0000);
`endif
        @(negedge clk);
        check("p0_wr_en_pulse", 32'(wr_en), 32'd0);
        check("p0_wr_data_hold", 32'(wr_data), 32'h112233);

        // full frame of FF bytes back-to-back
        ack();
        for (int p = 0; p < 8; p++) begin
            send(8'hFF); send(8'hFF); send(8'hFF);
            check($sformatf("ff_wr_en_%0d", p), 32'(wr_en), 32'd1);
            check($sformatf("ff_wr_addr_%0d", p), 32'(wr_addr), 32'(p));
            if (p == 3) begin
                check("ff_col_after4", 32'(col), 32'd0);
                check("ff_row_after4", 32'(row), 32'd1);
                check("ff_done_not_yet", 32'(frame_done), 32'd0);
            end
        end
        check("ff_frame_done", 32'(frame_done), 32'd1);
        check("ff_wr_data", 32'(wr_data), 32'hFFFFFF);
        check("ff_col_wrap", 32'(col), 32'd0);
        check("ff_row_wrap", 32'(row), 32'd0);
`ifdef CHECKSUM_EN
        exp_csum = 16'h17E8;
`else
        exp_csum = 16'h0000;
`endif
        check("ff_checksum", 32'(checksum), 32'(exp_csum));
        @(negedge clk);
        check("ff_busy_after", 32'(busy), 32'd0);

        // overflow in DONE
        send(8'h5A);
        check("ov_no_wr", 32'(wr_en), 32'd0);
        check("ov_set", 32'(overflow), 32'd1);
        check("ov_checksum_frozen", 32'(checksum), 32'(exp_csum));
        @(negedge clk);
        check("ov_sticky", 32'(overflow), 32'd1);
        check("ov_done_sticky", 32'(frame_done), 32'd1);
        ack();
        check("ack_overflow", 32'(overflow), 32'd0);
        check("ack_frame_done", 32'(frame_done), 32'd0);
        check("ack_busy", 32'(busy), 32'd0);
        check("ack_checksum", 32'(checksum), 32'd0);

        // resync: 4 bytes, ack, then a fresh pixel
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        ack();
        check("rs_col_clear", 32'(col), 32'd0);
        send(8'hAA); send(8'hBB); send(8'hCC);
        check("rs_wr_en", 32'(wr_en), 32'd1);
        check("rs_wr_addr", 32'(wr_addr), 32'd0);
        check("rs_wr_data", 32'(wr_data), 32'hAABBCC);

        // byte coincident with frame_ack is discarded
        ack();
        frame_ack = 1'b1;
        send(8'h55);
        frame_ack = 1'b0;
        check("sim_no_overflow", 32'(overflow), 32'd0);
        check("sim_idle", 32'(busy), 32'd0);
        send(8'h66); send(8'h77); send(8'h88);
        check("sim_wr_addr", 32'(wr_addr), 32'd0);
        check("sim_wr_data", 32'(wr_data), 32'h667788);

        // reset mid-pixel
        send(8'h12); send(8'h34);
        rst = 1'b0;
        @(negedge clk);
        check("mr_wr_en", 32'(wr_en), 32'd0);
        check("mr_wr_data", 32'(wr_data), 32'd0);
        check("mr_col", 32'(col), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        send(8'hDE); send(8'hAD); send(8'hBE);
        check("mr_next_wr_en", 32'(wr_en), 32'd1);
        check("mr_next_addr", 32'(wr_addr), 32'd0);
        check("mr_next_data", 32'(wr_data), 32'hDEADBE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
